// File: rtl/carp_gpio_pkg.sv
// Shared definitions for the Caravel GPIO controller: register group offsets,
// default window decode constants and the byte-lane merge helper.
package carp_gpio_pkg;

  localparam int unsigned WB_DW = 32;
  localparam int unsigned WB_SW = 4;

  // Register group selected by adr[4:2]; groups 6 and 7 are unmapped
  typedef enum logic [2:0] {
    REG_OUT  = 3'd0,
    REG_OE   = 3'd1,
    REG_IN   = 3'd2,
    REG_EN   = 3'd3,
    REG_PEND = 3'd4,
    REG_RISE = 3'd5
  } gpio_reg_e;

  localparam logic [31:0] GPIO_BASE_ADDR = 32'h3000_0000;
  localparam logic [31:0] GPIO_ADDR_MASK = 32'h0000_003F;

  // Replace the byte lanes of old_w selected by sel with the lanes of new_w
  function automatic logic [WB_DW-1:0] byte_merge(input logic [WB_DW-1:0] old_w,
                                                  input logic [WB_DW-1:0] new_w,
                                                  input logic [WB_SW-1:0] sel);
    logic [WB_DW-1:0] m;
    for (int b = 0; b < int'(WB_SW); b++) begin
      m[b*8 +: 8] = {8{sel[b]}};
    end
    return (old_w & ~m) | (new_w & m);
  endfunction

endpackage

// File: rtl/gpio_sync.sv
// Two-flop synchroniser for asynchronous pad inputs plus a third flop that
// holds the previous synchronised value for edge detection.
//   clk_i, rst_ni : clock, async active-low reset
//   d_i           : raw asynchronous inputs
//   sync_o        : synchronised inputs
//   rise_o/fall_o : one-cycle pulses on synchronised rising/falling edges
module gpio_sync #(
  parameter int unsigned W = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] sync_o,
  output logic [W-1:0] rise_o,
  output logic [W-1:0] fall_o
);

  logic [W-1:0] meta_q, meta_d;
  logic [W-1:0] sync_q, sync_d;
  logic [W-1:0] prev_q, prev_d;

  always_comb begin
    meta_d = d_i;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  // Edge pulses are decoded from flops so PEND sets on the next edge
  assign sync_o = sync_q;
  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/caravel_gpio_ctrl.sv
// Wishbone-slave GPIO controller behind the Caravel wrapper.
//   clk_i, rst_ni        : clock, async active-low reset
//   wbs_*                : Wishbone slave (1-cycle latency, one-cycle ack pulse)
//   gpio_i               : raw pad inputs (asynchronous)
//   gpio_o, gpio_oeb_no  : pad output value and active-low output enable
//   irq_o                : registered OR of pending-and-enabled edge interrupts
module caravel_gpio_ctrl
  import carp_gpio_pkg::*;
#(
  parameter int unsigned NUM_GPIO  = 38,
  parameter logic [31:0] BASE_ADDR = GPIO_BASE_ADDR,
  parameter logic [31:0] ADDR_MASK = GPIO_ADDR_MASK
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                wbs_stb_i,
  input  logic                wbs_cyc_i,
  input  logic                wbs_we_i,
  input  logic [3:0]          wbs_sel_i,
  input  logic [31:0]         wbs_adr_i,
  input  logic [31:0]         wbs_dat_i,
  output logic                wbs_ack_o,
  output logic [31:0]         wbs_dat_o,
  input  logic [NUM_GPIO-1:0] gpio_i,
  output logic [NUM_GPIO-1:0] gpio_o,
  output logic [NUM_GPIO-1:0] gpio_oeb_no,
  output logic                irq_o
);

  localparam int unsigned W     = NUM_GPIO;
  localparam int unsigned PAD_W = 64;

  logic [W-1:0] out_q, out_d;
  logic [W-1:0] oe_q, oe_d;
  logic [W-1:0] en_q, en_d;
  logic [W-1:0] pend_q, pend_d;
  logic [W-1:0] pol_q, pol_d;
  logic         ack_q, ack_d;
  logic [31:0]  dat_q, dat_d;
  logic         irq_q, irq_d;
  // Write captured at the request, committed at the end of the ack cycle
  logic         wr_q, wr_d;
  logic [2:0]   wgrp_q, wgrp_d;
  logic         whalf_q, whalf_d;
  logic [3:0]   wsel_q, wsel_d;
  logic [31:0]  wdat_q, wdat_d;

  logic [W-1:0] in_sync, in_rise, in_fall;
  logic         hit, req;
  logic [31:0]  rd_word;
  logic [W-1:0] clr_mask, set_mask;

  gpio_sync #(.W(W)) u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (gpio_i),
    .sync_o (in_sync),
    .rise_o (in_rise),
    .fall_o (in_fall)
  );

  // Select one 32-bit half of a register; bits at or above W read as 0
  function automatic logic [31:0] word_of(input logic [W-1:0] r, input logic half);
    logic [PAD_W-1:0] v;
    v = PAD_W'(r);
    return half ? v[63:32] : v[31:0];
  endfunction

  // Byte-lane write into one half; bits at or above W are dropped
  function automatic logic [W-1:0] merge_reg(input logic [W-1:0] cur, input logic half,
                                             input logic [3:0] sel, input logic [31:0] data);
    logic [PAD_W-1:0] v;
    v = PAD_W'(cur);
    if (half) v[63:32] = byte_merge(v[63:32], data, sel);
    else      v[31:0]  = byte_merge(v[31:0], data, sel);
    return v[W-1:0];
  endfunction

  // Bus decode, read mux, register writes and PEND update
  always_comb begin
    out_d    = out_q;
    oe_d     = oe_q;
    en_d     = en_q;
    pol_d    = pol_q;
    wr_d     = wr_q;
    wgrp_d   = wgrp_q;
    whalf_d  = whalf_q;
    wsel_d   = wsel_q;
    wdat_d   = wdat_q;
    clr_mask = '0;
    rd_word  = '0;

    hit = ((wbs_adr_i & ~ADDR_MASK) == BASE_ADDR);
    req = wbs_cyc_i & wbs_stb_i & hit & ~ack_q;

    case (gpio_reg_e'(wbs_adr_i[4:2]))
      REG_OUT:  rd_word = word_of(out_q, wbs_adr_i[5]);
      REG_OE:   rd_word = word_of(oe_q, wbs_adr_i[5]);
      REG_IN:   rd_word = word_of(in_sync, wbs_adr_i[5]);
      REG_EN:   rd_word = word_of(en_q, wbs_adr_i[5]);
      REG_PEND: rd_word = word_of(pend_q, wbs_adr_i[5]);
      REG_RISE: rd_word = word_of(pol_q, wbs_adr_i[5]);
      default:  rd_word = '0;
    endcase

    ack_d = req;
    dat_d = (req && !wbs_we_i) ? rd_word : 32'h0;

    if (req) begin
      wr_d    = wbs_we_i;
      wgrp_d  = wbs_adr_i[4:2];
      whalf_d = wbs_adr_i[5];
      wsel_d  = wbs_sel_i;
      wdat_d  = wbs_dat_i;
    end

    if (ack_q && wr_q) begin
      wr_d = 1'b0;
      case (gpio_reg_e'(wgrp_q))
        REG_OUT:  out_d    = merge_reg(out_q, whalf_q, wsel_q, wdat_q);
        REG_OE:   oe_d     = merge_reg(oe_q, whalf_q, wsel_q, wdat_q);
        REG_EN:   en_d     = merge_reg(en_q, whalf_q, wsel_q, wdat_q);
        REG_PEND: clr_mask = merge_reg('0, whalf_q, wsel_q, wdat_q);
        REG_RISE: pol_d    = merge_reg(pol_q, whalf_q, wsel_q, wdat_q);
        default:  ;
      endcase
    end

    // Edge capture is independent of EN and takes priority over W1C
    set_mask = (in_rise & pol_q) | (in_fall & ~pol_q);
    pend_d   = (pend_q & ~clr_mask) | set_mask;
    irq_d    = |(pend_q & en_q);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_q   <= '0;
      oe_q    <= '0;
      en_q    <= '0;
      pend_q  <= '0;
      pol_q   <= '0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
      irq_q   <= 1'b0;
      wr_q    <= 1'b0;
      wgrp_q  <= '0;
      whalf_q <= 1'b0;
      wsel_q  <= '0;
      wdat_q  <= '0;
    end else begin
      out_q   <= out_d;
      oe_q    <= oe_d;
      en_q    <= en_d;
      pend_q  <= pend_d;
      pol_q   <= pol_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      irq_q   <= irq_d;
      wr_q    <= wr_d;
      wgrp_q  <= wgrp_d;
      whalf_q <= whalf_d;
      wsel_q  <= wsel_d;
      wdat_q  <= wdat_d;
    end
  end

  assign wbs_ack_o   = ack_q;
  assign wbs_dat_o   = dat_q;
  assign gpio_o      = out_q;
  assign gpio_oeb_no = ~oe_q;
  assign irq_o       = irq_q;

endmodule

// File: tb/tb_caravel_gpio_ctrl.sv
// Directed bench for caravel_gpio_ctrl: register vectors from a table plus
// hand-written sequences for interrupt timing, W1C/edge collision, window
// decode and reset during an ack.
module tb_caravel_gpio_ctrl;

  localparam int unsigned N = 38;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         wbs_stb_i, wbs_cyc_i, wbs_we_i;
  logic [3:0]   wbs_sel_i;
  logic [31:0]  wbs_adr_i, wbs_dat_i;
  logic         wbs_ack_o;
  logic [31:0]  wbs_dat_o;
  logic [N-1:0] gpio_i, gpio_o, gpio_oeb_no;
  logic         irq_o;

  int errors = 0;
  int checks = 0;

  caravel_gpio_ctrl #(.NUM_GPIO(N)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .wbs_stb_i   (wbs_stb_i),
    .wbs_cyc_i   (wbs_cyc_i),
    .wbs_we_i    (wbs_we_i),
    .wbs_sel_i   (wbs_sel_i),
    .wbs_adr_i   (wbs_adr_i),
    .wbs_dat_i   (wbs_dat_i),
    .wbs_ack_o   (wbs_ack_o),
    .wbs_dat_o   (wbs_dat_o),
    .gpio_i      (gpio_i),
    .gpio_o      (gpio_o),
    .gpio_oeb_no (gpio_oeb_no),
    .irq_o       (irq_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Single transfer; ok=1 when ack is high exactly one cycle after the request
  task automatic bus(input logic [31:0] adr, input logic we, input logic [31:0] dat,
                     input logic [3:0] sel, output logic [31:0] rd, output logic ok);
    @(posedge clk_i); #1;
    ok = !wbs_ack_o;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr;  wbs_dat_i = dat;  wbs_sel_i = sel;
    @(posedge clk_i); #1;
    if (!wbs_ack_o) ok = 1'b0;
    rd = wbs_dat_o;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    @(posedge clk_i); #1;
    if (wbs_ack_o) ok = 1'b0;
  endtask

  logic [31:0] rd;
  logic        ok;

  initial begin
    vecs[0]  = '{32'h3000_0000, 1'b1, 32'hA5A5_A5A5, 4'b0101, 32'h0};
    vecs[1]  = '{32'h3000_0000, 1'b0, 32'h0,         4'b1111, 32'h00A5_00A5};
    vecs[2]  = '{32'h3000_0024, 1'b1, 32'hFFFF_FFFF, 4'b1111, 32'h0};
    vecs[3]  = '{32'h3000_0024, 1'b0, 32'h0,         4'b1111, 32'h0000_003F};
    vecs[4]  = '{32'h3000_000C, 1'b1, 32'h1234_5678, 4'b1100, 32'h0};
    vecs[5]  = '{32'h3000_000C, 1'b0, 32'h0,         4'b1111, 32'h1234_0000};
    vecs[6]  = '{32'h3000_0034, 1'b1, 32'hFFFF_FFFF, 4'b0001, 32'h0};
    vecs[7]  = '{32'h3000_0034, 1'b0, 32'h0,         4'b1111, 32'h0000_003F};
    vecs[8]  = '{32'h3000_0018, 1'b1, 32'hFFFF_FFFF, 4'b1111, 32'h0};
    vecs[9]  = '{32'h3000_0018, 1'b0, 32'h0,         4'b1111, 32'h0};
    vecs[10] = '{32'h3000_001C, 1'b0, 32'h0,         4'b1111, 32'h0};
    vecs[11] = '{32'h3000_0020, 1'b0, 32'h0,         4'b1111, 32'h0};
    vecs[12] = '{32'h3000_0008, 1'b0, 32'h0,         4'b1111, 32'h0};
    vecs[13] = '{32'h3000_0004, 1'b1, 32'h0000_FF00, 4'b0010, 32'h0};
    vecs[14] = '{32'h3000_0004, 1'b0, 32'h0,         4'b1111, 32'h0000_FF00};

    rst_ni = 1'b0;
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    wbs_sel_i = 4'h0; wbs_adr_i = 32'h0; wbs_dat_i = 32'h0;
    gpio_i = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i) rst_ni = 1'b1;

    // Reset state
    chk("rst_oeb", 64'(gpio_oeb_no), 64'h3F_FFFF_FFFF);
    chk("rst_gpio_o", 64'(gpio_o), 64'h0);
    chk("rst_irq", 64'(irq_o), 64'h0);
    chk("rst_ack", 64'(wbs_ack_o), 64'h0);
    chk("rst_dat", 64'(wbs_dat_o), 64'h0);
    for (int i = 0; i < 16; i++) begin
      bus(32'h3000_0000 + 32'(i * 4), 1'b0, 32'h0, 4'hF, rd, ok);
      chk($sformatf("rst_rd%0d_ack", i), 64'(ok), 64'h1);
      chk($sformatf("rst_rd%0d_dat", i), 64'(rd), 64'h0);
    end

    // Register table
    for (int i = 0; i < 15; i++) begin
      bus(vecs[i].adr, vecs[i].we, vecs[i].dat, vecs[i].sel, rd, ok);
      chk($sformatf("vec%0d_ack", i), 64'(ok), 64'h1);
      if (!vecs[i].we) chk($sformatf("vec%0d_rd", i), 64'(rd), 64'(vecs[i].exp_rd));
      if (i == 0) chk("gpio_o_after_out", 64'(gpio_o), 64'h00_00A5_00A5);
    end
    chk("gpio_o_final", 64'(gpio_o), 64'h00_00A5_00A5);
    chk("oeb_final", 64'(gpio_oeb_no), 64'h00_FFFF_00FF);

    // Back-to-back reads with stb held: ack every second cycle
    @(posedge clk_i); #1;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h3000_0000;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_i); #1;
      chk($sformatf("b2b_ack%0d", i), 64'(wbs_ack_o), (i % 2 == 0) ? 64'h1 : 64'h0);
      if (i % 2 == 0) chk($sformatf("b2b_dat%0d", i), 64'(wbs_dat_o), 64'h00A5_00A5);
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;

    // Rising-edge interrupt on pad 3
    bus(32'h3000_0014, 1'b1, 32'h8, 4'hF, rd, ok);
    bus(32'h3000_000C, 1'b1, 32'h8, 4'hF, rd, ok);
    chk("irq_idle", 64'(irq_o), 64'h0);
    gpio_i[3] = 1'b1;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    chk("irq_c2", 64'(irq_o), 64'h0);
    @(posedge clk_i); #1;
    chk("irq_c3", 64'(irq_o), 64'h0);
    @(posedge clk_i); #1;
    chk("irq_c4", 64'(irq_o), 64'h1);
    bus(32'h3000_0010, 1'b0, 32'h0, 4'hF, rd, ok);
    chk("pend_set", 64'(rd), 64'h8);
    bus(32'h3000_0008, 1'b0, 32'h0, 4'hF, rd, ok);
    chk("in_sync", 64'(rd), 64'h8);
    bus(32'h3000_0010, 1'b1, 32'h8, 4'hF, rd, ok);
    @(posedge clk_i); #1;
    chk("irq_cleared", 64'(irq_o), 64'h0);
    bus(32'h3000_0010, 1'b0, 32'h0, 4'hF, rd, ok);
    chk("pend_cleared", 64'(rd), 64'h0);

    // W1C committing on the same edge as a new rising edge: set wins
    gpio_i[3] = 1'b0;
    repeat (4) @(posedge clk_i);
    #1;
    gpio_i[3] = 1'b1;
    @(posedge clk_i); #1;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
    wbs_adr_i = 32'h3000_0010; wbs_dat_i = 32'h8; wbs_sel_i = 4'hF;
    @(posedge clk_i); #1;
    chk("collide_ack", 64'(wbs_ack_o), 64'h1);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    chk("collide_irq", 64'(irq_o), 64'h1);
    bus(32'h3000_0010, 1'b0, 32'h0, 4'hF, rd, ok);
    chk("collide_pend", 64'(rd), 64'h8);

    // Outside the window: no ack, data held at 0
    @(posedge clk_i); #1;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h3000_0040;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #1;
      chk($sformatf("oow_ack%0d", i), 64'(wbs_ack_o), 64'h0);
      chk($sformatf("oow_dat%0d", i), 64'(wbs_dat_o), 64'h0);
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;

    // Reset asserted during the ack cycle of an OUT write
    @(posedge clk_i); #1;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b1;
    wbs_adr_i = 32'h3000_0000; wbs_dat_i = 32'hFFFF_FFFF; wbs_sel_i = 4'hF;
    @(posedge clk_i); #1;
    chk("rstmid_ack", 64'(wbs_ack_o), 64'h1);
    #2 rst_ni = 1'b0;
    #1;
    chk("rstmid_ack_drop", 64'(wbs_ack_o), 64'h0);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i) rst_ni = 1'b1;
    chk("rstmid_gpio_o", 64'(gpio_o), 64'h0);
    chk("rstmid_oeb", 64'(gpio_oeb_no), 64'h3F_FFFF_FFFF);
    bus(32'h3000_0000, 1'b0, 32'h0, 4'hF, rd, ok);
    chk("rstmid_rd_ack", 64'(ok), 64'h1);
    chk("rstmid_rd", 64'(rd), 64'h0);
    @(posedge clk_i); #1;
    chk("rstmid_gpio_o_later", 64'(gpio_o), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
